// File: rtl/tx_descriptor_arbiter_if.sv
// Descriptor path of one egress port.
//   master : the arbiter (pops source FIFOs, presents a descriptor)
//   slave  : source FIFOs plus the TX serializer
// Signal names keep the arbiter's port names so the two views line up.
interface tx_descriptor_arbiter_if #(
  parameter int pN_SRC     = 4,
  parameter int pDEPTH_RAM = 4608
);
  localparam int AW = $clog2(pDEPTH_RAM);
  localparam int DW = 2 * AW + 2;

  logic [pN_SRC-1:0]    i_src_empty;
  logic [pN_SRC*DW-1:0] i_src_desc;
  logic [pN_SRC-1:0]    o_src_read;
  logic                 o_FIFO_empty;
  logic                 i_FIFO_read;
  logic [DW-1:0]        o_adress;
  logic                 i_TX_finish;

  modport master (
    input  i_src_empty, i_src_desc, i_FIFO_read, i_TX_finish,
    output o_src_read, o_FIFO_empty, o_adress
  );

  modport slave (
    output i_src_empty, i_src_desc, i_FIFO_read, i_TX_finish,
    input  o_src_read, o_FIFO_empty, o_adress
  );
endinterface

// File: rtl/tx_descriptor_arbiter.sv
// Per-frame round-robin arbiter between the source descriptor FIFOs of an
// egress port and its TX serializer. One descriptor is popped per frame and
// held stable on o_adress until the serializer signals end of frame.
// Optional build macro TXARB_STRICT_PRIO_EN: source 0 gets strict priority,
// the remaining sources share round-robin.
module tx_descriptor_arbiter #(
  parameter int pN_SRC     = 4,
  parameter int pDEPTH_RAM = 4608,
  parameter int pFIFO_LAT  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  tx_descriptor_arbiter_if.master bus,
  output logic [pN_SRC-1:0]       o_grant,
  output logic                    o_busy
);
  localparam int AW    = $clog2(pDEPTH_RAM);
  localparam int DW    = 2 * AW + 2;
  localparam int SEL_W = $clog2(pN_SRC);
  localparam int CNT_W = 2;

`ifdef TXARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, LOAD, HOLD} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [pN_SRC-1:0] grant_q, grant_d;
  logic [pN_SRC-1:0] src_read_q, src_read_d;
  logic              empty_q, empty_d;
  logic [DW-1:0]     adress_q, adress_d;
  logic              busy_q;

  logic [DW-1:0]     desc_arr [pN_SRC];
  logic              pick_vld;
  logic [SEL_W-1:0]  pick_idx;
  logic [SEL_W-1:0]  cand;

  for (genvar k = 0; k < pN_SRC; k++) begin : g_desc
    assign desc_arr[k] = bus.i_src_desc[k*DW +: DW];
  end

  // Pick the next non-empty source: scan from last+1 upward, wrapping.
  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    // Walk downward so the closest candidate after 'last' is written last.
    for (int i = pN_SRC; i >= 1; i--) begin
      cand = SEL_W'((int'(last_q) + i) % pN_SRC);
      if (!bus.i_src_empty[cand] && !(STRICT && cand == '0)) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    if (STRICT && !bus.i_src_empty[0]) begin
      pick_vld = 1'b1;
      pick_idx = '0;
    end
  end

  // Next-state and next-output logic of the frame FSM.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    src_read_d = '0;
    empty_d    = empty_q;
    adress_d   = adress_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          sel_d             = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          src_read_d        = grant_d;
          cnt_d             = '0;
          state_d           = REQ;
        end
      end
      REQ: state_d = LOAD;
      LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(pFIFO_LAT - 1)) begin
          // Captured even if the source now reports empty: the pop was
          // issued while it was non-empty, so the read data is valid.
          adress_d = desc_arr[sel_q];
          empty_d  = 1'b0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // A pop takes precedence; finish counts only once the pop happened,
        // and o_adress keeps its value since the serializer samples it late.
        if (bus.i_FIFO_read && !empty_q) begin
          empty_d = 1'b1;
        end else if (bus.i_TX_finish && empty_q) begin
          if (!(STRICT && sel_q == '0)) last_d = sel_q;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any frame in progress.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_q     <= SEL_W'(pN_SRC - 1);
      cnt_q      <= '0;
      grant_q    <= '0;
      src_read_q <= '0;
      empty_q    <= 1'b1;
      adress_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      src_read_q <= src_read_d;
      empty_q    <= empty_d;
      adress_q   <= adress_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.o_src_read   = src_read_q;
  assign bus.o_FIFO_empty = empty_q;
  assign bus.o_adress     = adress_q;
  assign o_grant          = grant_q;
  assign o_busy           = busy_q;

endmodule
